as5600_i2c_target: RTL and testbench
====================================

AS5600_I2C_TARGET -- requirements
Module: as5600_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h36: 7-bit I2C target address the block responds to.
REQ-002 Parameter STATUS_VAL, default 8'h20: constant returned for register 0x0B (magnet detected).
REQ-003 clock  input  1  main clock; single clock domain; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl  input  1  I2C clock from the bus master, asynchronous.
REQ-006 sda_in  input  1  sampled I2C data line, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain, external pull-up).
REQ-008 angle_value  input  12  live angle presented to the bus as the AS5600 RAW ANGLE/ANGLE value.
REQ-009 busy  output  1  high from a matching address byte until STOP or next START.
REQ-010 byte_sent  output  1  one-cycle pulse when a read byte's master ACK/NACK bit is sampled.
REQ-011 reg_ptr  output  8  current register pointer, for debug.

Function
REQ-012 scl and sda_in shall each pass through a 2-flop synchronizer; edge detection shall use the synchronized values (3-cycle detect latency).
REQ-013 START: synchronized sda falls while scl high; STOP: synchronized sda rises while scl high; both are recognized in any state.
REQ-014 Data shall be sampled on scl rising edges and sda_oe shall change only on the cycle after a detected scl falling edge; operation requires scl high and low phases of at least 6 clock cycles each.
REQ-015 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, TX, TX_ACK, WAIT.
REQ-016 IDLE -> ADDR on START; START in any other state -> ADDR (repeated start), bit counter cleared, sda_oe released.
REQ-017 ADDR shifts 8 bits MSB first; on 8th bit, address == DEV_ADDR -> ADDR_ACK, otherwise -> WAIT with sda_oe held 0.
REQ-018 ADDR_ACK drives sda_oe=1 for exactly one scl low-high-low period; then R/W=0 -> REG, R/W=1 -> TX.
REQ-019 On entering ADDR_ACK with R/W=1, angle_value shall be snapshotted into a 12-bit holding register; all bytes of that transaction read from the snapshot.
REQ-020 REG shifts 8 bits into reg_ptr, then REG_ACK (ACK as REQ-018) -> WDATA.
REQ-021 WDATA acknowledges every byte, discards data, increments reg_ptr per byte.
REQ-022 Register map: 0x0B = STATUS_VAL; 0x0C and 0x0E = {4'h0, snapshot[11:8]}; 0x0D and 0x0F = snapshot[7:0]; all others 8'h00.
REQ-023 TX loads the byte addressed by reg_ptr, drives bits MSB first (sda_oe = ~bit), then releases SDA for TX_ACK; reg_ptr increments after each byte.
REQ-024 TX_ACK samples master bit on scl rise and pulses byte_sent; ACK (0) -> TX with next byte; NACK (1) -> WAIT.
REQ-025 reg_ptr arithmetic is 8-bit modulo: 8'hFF increments to 8'h00.
REQ-026 reg_ptr persists across transactions; a read without a preceding pointer write starts at the current reg_ptr.
REQ-027 STOP in any state -> IDLE, sda_oe=0, busy=0 on the following cycle; partially shifted bytes are discarded.
REQ-028 WAIT ignores all bits until START or STOP.
REQ-029 busy asserts on entry to ADDR_ACK and deasserts on STOP, START, or entry to WAIT.

Reset
REQ-030 On reset: state=IDLE, sda_oe=0, busy=0, byte_sent=0, reg_ptr=8'h00, snapshot=12'h000, synchronizers=1'b1.
REQ-031 Reset mid-transaction shall release SDA on the next clock; the block ignores the bus until the next START.

Verification
REQ-032 Write 0x36/W, 0x0C, repeated START, 0x36/R, read 2 bytes (ACK, NACK), angle_value=12'hABC -> ACKs driven, bytes 0x0A, 0xBC, two byte_sent pulses, reg_ptr=0x0E.
REQ-033 Address 0x37 -> sda_oe stays 0 through STOP, busy never asserts, reg_ptr unchanged.
REQ-034 Read from 0x0C with angle_value changed 12'h123 -> 12'hFFF between bytes -> 0x01, 0x23 returned.
REQ-035 Pointer 0x0B, read 1 byte -> 0x20; pointer 0xFF, read 2 bytes -> 0x00, 0x00, reg_ptr=0x01.
REQ-036 reset asserted during 4th bit of a read byte -> sda_oe=0 next cycle, state IDLE; subsequent full read succeeds.
REQ-037 STOP after 3 address bits -> IDLE, no ACK; following valid transaction completes normally.

Source files
------------

// File: rtl/as5600_i2c_target.sv
// I2C target emulating the AS5600 register read path: angle registers, status byte
// and an auto-incrementing register pointer, all behind a bit-level bus FSM.
module as5600_i2c_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h36,
    parameter logic [7:0] STATUS_VAL = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl,
    input  logic        sda_in,
    input  logic [11:0] angle_value,
    output logic        sda_oe,
    output logic        busy,
    output logic        byte_sent,
    output logic [7:0]  reg_ptr
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, TX, TX_ACK, WAIT
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        rw_q, rw_d;
    logic        phase_q, phase_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        byte_sent_q, byte_sent_d;
    logic [7:0]  reg_ptr_q, reg_ptr_d;
    logic [11:0] snap_q, snap_d;

    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rd_byte;

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = sda_prev_q & ~sda_s2_q & scl_s2_q & scl_prev_q;
    assign stop_det  = ~sda_prev_q & sda_s2_q & scl_s2_q & scl_prev_q;

    always_comb begin
        case (reg_ptr_q)
            8'h0B:        rd_byte = STATUS_VAL;
            8'h0C, 8'h0E: rd_byte = {4'h0, snap_q[11:8]};
            8'h0D, 8'h0F: rd_byte = snap_q[7:0];
            default:      rd_byte = 8'h00;
        endcase
    end

    // phase_q: in the ACK states it marks "ACK already driven"; in TX it marks
    // "current byte loaded" so the byte after a master ACK loads on the next fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_sh_d     = tx_sh_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        byte_sent_d = 1'b0;
        reg_ptr_d   = reg_ptr_q;
        snap_d      = snap_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (shift_q[6:0] == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = sda_s2_q;
                                busy_d  = 1'b1;
                                phase_d = 1'b0;
                                if (sda_s2_q) snap_d = angle_value;
                            end else begin
                                state_d  = WAIT;
                                busy_d   = 1'b0;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK, REG_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            if (state_q == REG_ACK) begin
                                state_d  = WDATA;
                                sda_oe_d = 1'b0;
                                phase_d  = 1'b0;
                            end else if (rw_q) begin
                                state_d  = TX;
                                tx_sh_d  = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                                phase_d  = 1'b1;
                            end else begin
                                state_d  = REG;
                                sda_oe_d = 1'b0;
                                phase_d  = 1'b0;
                            end
                        end
                    end
                end
                REG, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            state_d   = REG_ACK;
                            phase_d   = 1'b0;
                            if (state_q == REG) reg_ptr_d = {shift_q[6:0], sda_s2_q};
                            else                reg_ptr_d = reg_ptr_q + 8'd1;
                        end
                    end
                end
                TX: begin
                    if (scl_rise && phase_q) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (!phase_q) begin
                            tx_sh_d   = rd_byte;
                            sda_oe_d  = ~rd_byte[7];
                            phase_d   = 1'b1;
                            bit_cnt_d = 4'd0;
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            state_d   = TX_ACK;
                            reg_ptr_d = reg_ptr_q + 8'd1;
                            bit_cnt_d = 4'd0;
                        end else begin
                            tx_sh_d  = {tx_sh_q[6:0], 1'b0};
                            sda_oe_d = ~tx_sh_q[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        byte_sent_d = 1'b1;
                        if (sda_s2_q) begin
                            state_d = WAIT;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = TX;
                            phase_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            scl_prev_q  <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_sh_q     <= 8'h00;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            byte_sent_q <= 1'b0;
            reg_ptr_q   <= 8'h00;
            snap_q      <= 12'h000;
        end else begin
            scl_s1_q    <= scl;
            scl_s2_q    <= scl_s1_q;
            scl_prev_q  <= scl_s2_q;
            sda_s1_q    <= sda_in;
            sda_s2_q    <= sda_s1_q;
            sda_prev_q  <= sda_s2_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_sh_q     <= tx_sh_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            byte_sent_q <= byte_sent_d;
            reg_ptr_q   <= reg_ptr_d;
            snap_q      <= snap_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign byte_sent = byte_sent_q;
    assign reg_ptr   = reg_ptr_q;

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Bench for as5600_i2c_target: a bit-banged I2C master on a wired-AND SDA line,
// a table of pointer-write/read transactions and hand-written corner sequences.
module tb_as5600_i2c_target;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [11:0] angle_value = 12'h000;
    logic        sda_oe, busy, byte_sent;
    logic [7:0]  reg_ptr;
    logic        sda_bus;

    assign sda_bus = m_sda & ~sda_oe;

    as5600_i2c_target dut (
        .clock       (clock),
        .reset       (reset),
        .scl         (m_scl),
        .sda_in      (sda_bus),
        .angle_value (angle_value),
        .sda_oe      (sda_oe),
        .busy        (busy),
        .byte_sent   (byte_sent),
        .reg_ptr     (reg_ptr)
    );

    always #5 clock = ~clock;

    int sent_cnt = 0;
    int busy_cyc = 0;
    int oe_cyc   = 0;
    always @(posedge clock) begin
        if (byte_sent) sent_cnt <= sent_cnt + 1;
        if (busy)      busy_cyc <= busy_cyc + 1;
        if (sda_oe)    oe_cyc   <= oe_cyc + 1;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; cyc(4);
        m_scl = 1'b1; cyc(8);
        m_sda = 1'b0; cyc(8);
        m_scl = 1'b0; cyc(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; cyc(4);
        m_scl = 1'b1; cyc(8);
        m_sda = 1'b1; cyc(8);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; cyc(4);
        m_scl = 1'b1; cyc(8);
        m_scl = 1'b0; cyc(4);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; cyc(4);
        m_scl = 1'b1; cyc(4);
        b = sda_bus; cyc(4);
        m_scl = 1'b0; cyc(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    // Optional pointer write, repeated START, read of 1 or 2 bytes (last NACKed), STOP.
    task automatic read_txn(input bit set_ptr, input logic [7:0] ptr,
                            input logic [11:0] ang_a, input logic [11:0] ang_b,
                            input int nbytes, output logic [7:0] d0, output logic [7:0] d1,
                            output int acks, output logic busy_mid);
        logic a;
        acks = 0;
        d1 = 8'h00;
        angle_value = ang_a;
        if (set_ptr) begin
            i2c_start();
            write_byte(8'h6C, a); acks += int'(a);
            write_byte(ptr, a);   acks += int'(a);
        end
        i2c_start();
        write_byte(8'h6D, a); acks += int'(a);
        busy_mid = busy;
        read_byte(d0, nbytes > 1);
        angle_value = ang_b;
        if (nbytes > 1) read_byte(d1, 1'b0);
        i2c_stop();
    endtask

    typedef struct {
        logic [7:0]  ptr;
        logic [11:0] ang_a;
        logic [11:0] ang_b;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  eptr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] d0, d1;
        int acks, s0, b0, o0;
        logic bm, a;

        vecs[0] = '{8'h0C, 12'hABC, 12'hABC, 8'h0A, 8'hBC, 8'h0E};
        vecs[1] = '{8'h0C, 12'h123, 12'hFFF, 8'h01, 8'h23, 8'h0E};
        vecs[2] = '{8'hFF, 12'h5A5, 12'h000, 8'h00, 8'h00, 8'h01};
        vecs[3] = '{8'h0E, 12'h7F1, 12'h000, 8'h07, 8'hF1, 8'h10};
        vecs[4] = '{8'h0D, 12'h3C4, 12'h111, 8'hC4, 8'h03, 8'h0F};
        vecs[5] = '{8'h0A, 12'h8E2, 12'h000, 8'h00, 8'h20, 8'h0C};

        cyc(5);
        reset = 1'b0;
        cyc(5);
        check("reset sda_oe", sda_oe, 0);
        check("reset busy", busy, 0);
        check("reset byte_sent", byte_sent, 0);
        check("reset reg_ptr", reg_ptr, 8'h00);
        $display("txn reset: sda_oe=%0b busy=%0b reg_ptr=%02h", sda_oe, busy, reg_ptr);

        for (int v = 0; v < 6; v++) begin
            s0 = sent_cnt;
            read_txn(1'b1, vecs[v].ptr, vecs[v].ang_a, vecs[v].ang_b, 2, d0, d1, acks, bm);
            $display("txn vec%0d ptr=%02h bytes=%02h %02h reg_ptr=%02h", v, vecs[v].ptr, d0, d1, reg_ptr);
            check($sformatf("vec%0d acks", v), acks, 3);
            check($sformatf("vec%0d byte0", v), d0, vecs[v].e0);
            check($sformatf("vec%0d byte1", v), d1, vecs[v].e1);
            check($sformatf("vec%0d byte_sent pulses", v), sent_cnt - s0, 2);
            check($sformatf("vec%0d reg_ptr", v), reg_ptr, vecs[v].eptr);
            check($sformatf("vec%0d busy mid", v), bm, 1);
            check($sformatf("vec%0d busy after stop", v), busy, 0);
        end

        // Single-byte read of the status register.
        s0 = sent_cnt;
        read_txn(1'b1, 8'h0B, 12'h456, 12'h456, 1, d0, d1, acks, bm);
        $display("txn status ptr=0B byte=%02h reg_ptr=%02h", d0, reg_ptr);
        check("status acks", acks, 3);
        check("status byte", d0, 8'h20);
        check("status byte_sent pulses", sent_cnt - s0, 1);
        check("status reg_ptr", reg_ptr, 8'h0C);

        // Foreign address: no ACK, no busy, pointer untouched.
        b0 = busy_cyc; o0 = oe_cyc;
        i2c_start();
        write_byte(8'h6E, a);
        check("addr 37 ack", a, 0);
        write_byte(8'h0C, a);
        check("addr 37 data ack", a, 0);
        i2c_stop();
        $display("txn addr37 reg_ptr=%02h", reg_ptr);
        check("addr 37 sda_oe cycles", oe_cyc - o0, 0);
        check("addr 37 busy cycles", busy_cyc - b0, 0);
        check("addr 37 reg_ptr", reg_ptr, 8'h0C);

        // STOP after three address bits, then a normal transaction.
        b0 = busy_cyc; o0 = oe_cyc;
        i2c_start();
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        check("early stop sda_oe cycles", oe_cyc - o0, 0);
        check("early stop busy cycles", busy_cyc - b0, 0);
        read_txn(1'b1, 8'h0D, 12'h456, 12'h456, 2, d0, d1, acks, bm);
        $display("txn early-stop then read bytes=%02h %02h reg_ptr=%02h", d0, d1, reg_ptr);
        check("after early stop acks", acks, 3);
        check("after early stop byte0", d0, 8'h56);
        check("after early stop byte1", d1, 8'h04);
        check("after early stop reg_ptr", reg_ptr, 8'h0F);

        // Write with data bytes, then a read with no pointer write.
        acks = 0;
        i2c_start();
        write_byte(8'h6C, a); acks += int'(a);
        write_byte(8'h0D, a); acks += int'(a);
        write_byte(8'h55, a); acks += int'(a);
        write_byte(8'hAA, a); acks += int'(a);
        i2c_stop();
        $display("txn write data reg_ptr=%02h", reg_ptr);
        check("wdata acks", acks, 4);
        check("wdata reg_ptr", reg_ptr, 8'h0F);
        read_txn(1'b0, 8'h00, 12'h9A7, 12'h000, 1, d0, d1, acks, bm);
        $display("txn read-only byte=%02h reg_ptr=%02h", d0, reg_ptr);
        check("read-only acks", acks, 1);
        check("read-only byte", d0, 8'hA7);
        check("read-only reg_ptr", reg_ptr, 8'h10);

        // Reset while the target drives the 4th bit of a read byte (0x0A).
        angle_value = 12'hABC;
        i2c_start();
        write_byte(8'h6C, a);
        write_byte(8'h0C, a);
        i2c_start();
        write_byte(8'h6D, a);
        for (int i = 0; i < 3; i++) read_bit(bm);
        m_sda = 1'b1; cyc(4);
        m_scl = 1'b1; cyc(2);
        check("pre-reset sda_oe", sda_oe, 1);
        reset = 1'b1;
        cyc(1);
        check("reset mid-read sda_oe", sda_oe, 0);
        check("reset mid-read busy", busy, 0);
        reset = 1'b0;
        cyc(2);
        m_scl = 1'b0; cyc(4);
        i2c_stop();
        check("reset mid-read reg_ptr", reg_ptr, 8'h00);
        read_txn(1'b1, 8'h0C, 12'h2B7, 12'h2B7, 2, d0, d1, acks, bm);
        $display("txn post-reset read bytes=%02h %02h reg_ptr=%02h", d0, d1, reg_ptr);
        check("post-reset acks", acks, 3);
        check("post-reset byte0", d0, 8'h02);
        check("post-reset byte1", d1, 8'hB7);
        check("post-reset reg_ptr", reg_ptr, 8'h0E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
